// File: rtl/hpb_multi_if.sv
// Host command and RCB write bus for hpb_multi.
// The master side is the host plus the targets; the slave side is the dispatcher.
interface hpb_multi_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_TARGETS = 4
);
    // host command channel
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [3:0]                cfg_target;
    logic [ADDR_WIDTH-1:0]     cfg_addr;
    logic [DATA_WIDTH/8-1:0]   cfg_byte_en;
    logic [DATA_WIDTH-1:0]     cfg_data;

    // target write channel
    logic [NUM_TARGETS-1:0]    wr_req;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_byte_en;
    logic [NUM_TARGETS-1:0]    wr_done;

    // status
    logic                      err_valid;
    logic [1:0]                err_code;
    logic [3:0]                err_target;
    logic                      busy;
    logic [15:0]               wr_count;
    logic [15:0]               err_count;

    modport master (
        output cfg_valid, cfg_target, cfg_addr, cfg_byte_en, cfg_data, wr_done,
        input  cfg_ready, wr_req, wr_addr, wr_data, wr_byte_en,
        input  err_valid, err_code, err_target, busy, wr_count, err_count
    );

    modport slave (
        input  cfg_valid, cfg_target, cfg_addr, cfg_byte_en, cfg_data, wr_done,
        output cfg_ready, wr_req, wr_addr, wr_data, wr_byte_en,
        output err_valid, err_code, err_target, busy, wr_count, err_count
    );
endinterface

// File: rtl/hpb_multi.sv
// hpb_multi: queues host write commands in a small FIFO and dispatches them one
// at a time to one of NUM_TARGETS RCB targets, waiting for wr_done or a timeout.
// A popped command sits in the command register for one IDLE cycle before it is
// decoded, so wr_req rises two edges after the command becomes available.
module hpb_multi #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 16,
    parameter int NUM_TARGETS    = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    hpb_multi_if.slave bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef struct packed {
        logic [3:0]            target;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BE_W-1:0]       byte_en;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state, state_nxt;
    cmd_t                   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count;
    logic                   full, empty, push, pop;
    cmd_t                   in_cmd, cmd;
    logic                   cmd_loaded;
    logic                   tgt_ok, done_sel;
    logic                   issue, inv_err, complete, timeout;
    logic [NUM_TARGETS-1:0] wr_req;
    logic [TMO_W-1:0]       wait_cnt;
    logic                   err_valid;
    logic [1:0]             err_code;
    logic [3:0]             err_target;
    logic [15:0]            wr_count, err_count;

    assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign push   = bus.cfg_valid && !full;
    assign in_cmd = '{target: bus.cfg_target, addr: bus.cfg_addr,
                      byte_en: bus.cfg_byte_en, data: bus.cfg_data};

    assign tgt_ok   = (32'(cmd.target) < NUM_TARGETS);
    // wr_req is one-hot in WAIT, so masking selects only the active target's done
    assign done_sel = |(bus.wr_done & wr_req);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and per-cycle actions: load, decode, complete or time out
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        inv_err   = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_loaded) begin
                    if (tgt_ok) begin
                        issue     = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        inv_err = 1'b1;
                    end
                end else if (!empty) begin
                    pop = 1'b1;
                end
            end
            WAIT: begin
                // completion wins over a coincident timeout
                if (done_sel) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TMO_LAST)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO pointers and occupancy; push and pop together keep the count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_cmd;
    end

    // Command register, request drive and wait counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd        <= '0;
            cmd_loaded <= 1'b0;
            wr_req     <= '0;
            wait_cnt   <= '0;
        end else begin
            if (pop) begin
                cmd        <= fifo_mem[rd_ptr];
                cmd_loaded <= 1'b1;
            end else if (issue || inv_err) begin
                cmd_loaded <= 1'b0;
            end
            if (issue) begin
                wr_req   <= NUM_TARGETS'(1) << cmd.target;
                wait_cnt <= '0;
            end else if (complete || timeout) begin
                wr_req <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + TMO_W'(1);
            end
        end
    end

    // Error pulse and report of the failing command's target
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_valid  <= 1'b0;
            err_code   <= 2'd0;
            err_target <= 4'd0;
        end else begin
            err_valid <= inv_err || timeout;
            if (inv_err || timeout) begin
                err_code   <= inv_err ? 2'd1 : 2'd2;
                err_target <= cmd.target;
            end
        end
    end

    // Saturating completion and error counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_count  <= '0;
            err_count <= '0;
        end else begin
            if (complete && (wr_count != 16'hFFFF))
                wr_count <= wr_count + 16'd1;
            if ((inv_err || timeout) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

    assign bus.cfg_ready  = !full;
    assign bus.wr_req     = wr_req;
    assign bus.wr_addr    = cmd.addr;
    assign bus.wr_data    = cmd.data;
    assign bus.wr_byte_en = cmd.byte_en;
    assign bus.err_valid  = err_valid;
    assign bus.err_code   = err_code;
    assign bus.err_target = err_target;
    assign bus.busy       = (state != IDLE) || !empty || cmd_loaded;
    assign bus.wr_count   = wr_count;
    assign bus.err_count  = err_count;
endmodule

// File: tb/tb_hpb_multi.sv
// Directed bench for hpb_multi with NUM_TARGETS=4, FIFO_DEPTH=4, TIMEOUT_CYCLES=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hpb_multi;
    localparam int DW = 128;
    localparam int AW = 16;
    localparam int NT = 4;
    localparam int FD = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hpb_multi_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(NT)) bus ();

    hpb_multi #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(NT),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // drive one command at a falling edge; returns at the falling edge after the push
    task automatic send(input logic [3:0] tgt, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW/8-1:0] be);
        bus.cfg_valid   = 1'b1;
        bus.cfg_target  = tgt;
        bus.cfg_addr    = addr;
        bus.cfg_data    = data;
        bus.cfg_byte_en = be;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready tgt=%0d got=%b exp=1", tgt, bus.cfg_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.wr_req !== 4'b0) begin errors++; $display("FAIL rst_wr_req got=%b exp=0", bus.wr_req); end
        checks++; if (bus.err_valid !== 1'b0 || bus.err_code !== 2'd0 || bus.err_target !== 4'd0) begin
            errors++; $display("FAIL rst_err got=%b/%0d/%0d exp=0/0/0", bus.err_valid, bus.err_code, bus.err_target); end
        checks++; if (bus.wr_count !== 16'd0 || bus.err_count !== 16'd0) begin
            errors++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", bus.wr_count, bus.err_count); end
        checks++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL rst_busy_ready got=%b/%b exp=0/1", bus.busy, bus.cfg_ready); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        send(4'd2, 16'h0040, {16{8'hA5}}, 16'hFFFF);
        checks++; if (bus.wr_req !== 4'b0) begin errors++; $display("FAIL single_lat1 got=%b exp=0000", bus.wr_req); end
        @(negedge clk);
        checks++; if (bus.wr_req !== 4'b0) begin errors++; $display("FAIL single_lat2 got=%b exp=0000", bus.wr_req); end
        @(negedge clk);
        checks++; if (bus.wr_req !== 4'b0100) begin errors++; $display("FAIL single_req got=%b exp=0100", bus.wr_req); end
        checks++; if (bus.wr_addr !== 16'h0040 || bus.wr_data !== {16{8'hA5}} || bus.wr_byte_en !== 16'hFFFF) begin
            errors++; $display("FAIL single_payload got addr=%h be=%h exp addr=0040 be=ffff", bus.wr_addr, bus.wr_byte_en); end
        bus.wr_done = 4'b0001;                // another target's done must be ignored
        @(negedge clk);
        bus.wr_done = 4'b0;
        checks++; if (bus.wr_req !== 4'b0100 || bus.wr_addr !== 16'h0040 || bus.wr_count !== 16'd0) begin
            errors++; $display("FAIL single_hold got req=%b addr=%h cnt=%0d exp 0100/0040/0", bus.wr_req, bus.wr_addr, bus.wr_count); end
        repeat (2) @(negedge clk);
        bus.wr_done = 4'b0100;
        @(negedge clk);
        bus.wr_done = 4'b0;
        checks++; if (bus.wr_req !== 4'b0 || bus.wr_count !== 16'd1 || bus.err_count !== 16'd0) begin
            errors++; $display("FAIL single_done got req=%b wr=%0d err=%0d exp 0000/1/0", bus.wr_req, bus.wr_count, bus.err_count); end
        bus.wr_done = 4'b1111;                // done while idle must be ignored
        @(negedge clk);
        bus.wr_done = 4'b0;
        @(negedge clk);
        checks++; if (bus.wr_count !== 16'd1 || bus.busy !== 1'b0 || bus.err_valid !== 1'b0) begin
            errors++; $display("FAIL idle_done got wr=%0d busy=%b errv=%b exp 1/0/0", bus.wr_count, bus.busy, bus.err_valid); end
    endtask

    task automatic test_invalid();
        send(4'd7, 16'h0077, 128'h1, 16'h0001);
        @(negedge clk);
        checks++; if (bus.wr_req !== 4'b0 || bus.err_valid !== 1'b0) begin
            errors++; $display("FAIL inv_early got req=%b errv=%b exp 0000/0", bus.wr_req, bus.err_valid); end
        @(negedge clk);
        checks++; if (bus.err_valid !== 1'b1 || bus.err_code !== 2'd1 || bus.err_target !== 4'd7 || bus.wr_req !== 4'b0) begin
            errors++; $display("FAIL inv_err got v=%b code=%0d tgt=%0d req=%b exp 1/1/7/0000",
                               bus.err_valid, bus.err_code, bus.err_target, bus.wr_req); end
        @(negedge clk);
        checks++; if (bus.err_valid !== 1'b0 || bus.err_count !== 16'd1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL inv_after got v=%b cnt=%0d busy=%b exp 0/1/0", bus.err_valid, bus.err_count, bus.busy); end
    endtask

    // five commands, no completions: fill the FIFO, then every command times out in order
    task automatic test_fifo_full();
        logic [3:0]  tg [5];
        logic [3:0]  exp_req;
        logic [15:0] exp_addr;
        int gap, hi;
        tg = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        for (int i = 0; i < 5; i++) send(tg[i], 16'h0100 + 16'(i), DW'(i), '1);
        checks++; if (bus.cfg_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL full_ready got ready=%b busy=%b exp 0/1", bus.cfg_ready, bus.busy); end
        for (int i = 0; i < 5; i++) begin
            exp_req  = 4'b0001 << tg[i];
            exp_addr = 16'h0100 + 16'(i);
            gap = 0;
            while (bus.wr_req === 4'b0 && gap < 40) begin @(negedge clk); gap++; end
            checks++; if (bus.wr_req !== exp_req || bus.wr_addr !== exp_addr || bus.wr_data !== DW'(i)) begin
                errors++; $display("FAIL order_%0d got req=%b addr=%h exp req=%b addr=%h", i, bus.wr_req, bus.wr_addr, exp_req, exp_addr); end
            if (i > 0) begin
                checks++; if (gap !== 2) begin errors++; $display("FAIL gap_%0d got=%0d exp=2", i, gap); end
            end
            hi = 0;
            while (bus.wr_req !== 4'b0 && hi < 40) begin hi++; @(negedge clk); end
            if (i > 0) begin
                checks++; if (hi !== TO) begin errors++; $display("FAIL tmo_len_%0d got=%0d exp=%0d", i, hi, TO); end
            end
            checks++; if (bus.err_valid !== 1'b1 || bus.err_code !== 2'd2 || bus.err_target !== tg[i]) begin
                errors++; $display("FAIL tmo_err_%0d got v=%b code=%0d tgt=%0d exp 1/2/%0d",
                                   i, bus.err_valid, bus.err_code, bus.err_target, tg[i]); end
        end
        @(negedge clk);
        checks++; if (bus.err_count !== 16'd6 || bus.wr_count !== 16'd1 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL full_end got err=%0d wr=%0d busy=%b ready=%b exp 6/1/0/1",
                               bus.err_count, bus.wr_count, bus.busy, bus.cfg_ready); end
    endtask

    // done arrives in the very cycle the timeout would fire
    task automatic test_done_at_timeout();
        int n;
        send(4'd1, 16'h0200, 128'hBEEF, 16'h00FF);
        n = 0;
        while (bus.wr_req === 4'b0 && n < 10) begin @(negedge clk); n++; end
        checks++; if (bus.wr_req !== 4'b0010) begin errors++; $display("FAIL race_req got=%b exp=0010", bus.wr_req); end
        repeat (TO - 1) @(negedge clk);
        bus.wr_done = 4'b0010;
        @(negedge clk);
        bus.wr_done = 4'b0;
        checks++; if (bus.wr_req !== 4'b0 || bus.err_valid !== 1'b0) begin
            errors++; $display("FAIL race_err got req=%b errv=%b exp 0000/0", bus.wr_req, bus.err_valid); end
        checks++; if (bus.wr_count !== 16'd2 || bus.err_count !== 16'd6) begin
            errors++; $display("FAIL race_counts got wr=%0d err=%0d exp 2/6", bus.wr_count, bus.err_count); end
    endtask

    task automatic test_reset_in_wait();
        int bad;
        send(4'd0, 16'h0300, 128'h3, '1);
        send(4'd1, 16'h0301, 128'h4, '1);
        send(4'd2, 16'h0302, 128'h5, '1);
        checks++; if (bus.wr_req !== 4'b0001 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rw_pre got req=%b busy=%b exp 0001/1", bus.wr_req, bus.busy); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.wr_req !== 4'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL rw_reset got req=%b busy=%b ready=%b exp 0000/0/1", bus.wr_req, bus.busy, bus.cfg_ready); end
        checks++; if (bus.wr_count !== 16'd0 || bus.err_count !== 16'd0 || bus.err_code !== 2'd0) begin
            errors++; $display("FAIL rw_counts got wr=%0d err=%0d code=%0d exp 0/0/0", bus.wr_count, bus.err_count, bus.err_code); end
        reset_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.wr_req !== 4'b0 || bus.err_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rw_discard got=%0d bad cycles exp=0", bad); end
    endtask

    initial begin
        bus.cfg_valid   = 1'b0;
        bus.cfg_target  = 4'd0;
        bus.cfg_addr    = '0;
        bus.cfg_byte_en = '0;
        bus.cfg_data    = '0;
        bus.wr_done     = '0;
        test_reset();
        test_single();
        test_invalid();
        test_fifo_full();
        test_done_at_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpb_multi.md
HPB_MULTI -- requirements
Module: hpb_multi

Interface
REQ-001 Parameter DATA_WIDTH, 128: write data width in bits; byte-enable width is DATA_WIDTH/8.
REQ-002 Parameter ADDR_WIDTH, 16: RAM write address width.
REQ-003 Parameter NUM_TARGETS, 4: number of RCB targets, 1..16.
REQ-004 Parameter FIFO_DEPTH, 4: command FIFO entries, power of 2, at least 2.
REQ-005 Parameter TIMEOUT_CYCLES, 1024: maximum cycles to wait for wr_done; 0 disables the timeout.
REQ-006 clk  in  1  core clock.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 cfg_valid  in  1  host command valid; already synchronised to clk.
REQ-009 cfg_ready  out  1  FIFO can accept a command.
REQ-010 cfg_target  in  4  target RCB index.
REQ-011 cfg_addr  in  ADDR_WIDTH  write address.
REQ-012 cfg_byte_en  in  DATA_WIDTH/8  byte enables.
REQ-013 cfg_data  in  DATA_WIDTH  write data.
REQ-014 wr_req  out  NUM_TARGETS  per-target write request, one-hot or zero.
REQ-015 wr_addr / wr_data / wr_byte_en  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  broadcast to all targets.
REQ-016 wr_done  in  NUM_TARGETS  per-target write completion, single-cycle pulse.
REQ-017 err_valid  out  1  single-cycle error pulse.
REQ-018 err_code  out  2  error code: 1 = invalid target, 2 = timeout.
REQ-019 err_target  out  4  target index of the failed command.
REQ-020 busy  out  1  FSM is not IDLE or the FIFO is not empty.
REQ-021 wr_count / err_count  out  16 each  completed writes and errors; both saturate at 16'hFFFF.

Function
REQ-022 cfg_ready SHALL equal the FIFO not-full flag, registered-free and independent of cfg_valid.
REQ-023 A push SHALL occur when cfg_valid and cfg_ready are both high on a clk edge.
REQ-024 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and commands SHALL be issued strictly in arrival order.
REQ-026 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-027 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into the command register on the next edge.
  - Valid target (cfg_target < NUM_TARGETS): go to WAIT with wr_req[target] = 1.
  - Invalid target: stay in IDLE and pulse err_valid with err_code 1.
REQ-028 With the FIFO empty and the FSM in IDLE, wr_req SHALL assert on the second clk edge after the accepting cfg handshake edge.
REQ-029 wr_addr, wr_data and wr_byte_en SHALL come from the command register and remain stable while any wr_req bit is high.
REQ-030 In WAIT, a wait counter SHALL start at 0 and increment each cycle.
REQ-031 In WAIT, wr_done of the selected target SHALL, on the next edge, clear wr_req, increment wr_count and return the FSM to IDLE.
REQ-032 wr_done on non-selected targets, or in IDLE, SHALL be ignored.
REQ-033 In WAIT, when TIMEOUT_CYCLES != 0 and the wait counter reaches TIMEOUT_CYCLES-1 without wr_done:
  - clear wr_req;
  - pulse err_valid with err_code 2;
  - return to IDLE.
REQ-034 If wr_done coincides with timeout expiry, the completion SHALL take priority and no error SHALL be raised.
REQ-035 Each err_valid pulse SHALL increment err_count.
REQ-036 The FSM SHALL leave back-to-back commands one IDLE cycle apart, so a new wr_req rises no earlier than the second edge after the previous one falls.
REQ-037 At most one wr_req bit SHALL be high at any time.

Reset
REQ-038 While reset_n is low at a clk edge, the block SHALL set:
  - FSM to IDLE and FIFO empty;
  - wr_req = 0, err_valid = 0, err_code = 0, err_target = 0;
  - wr_count = 0, err_count = 0, wait counter = 0;
  - command register = 0, busy = 0, cfg_ready = 1.
REQ-039 A reset during WAIT SHALL drop wr_req on that edge and discard all queued commands.

Verification
REQ-040 Command target=2, addr=16'h0040, data=128'hA5..A5, byte_en=16'hFFFF; wr_done[2] pulsed 3 cycles after wr_req rises.
  - Response: wr_req = 4'b0100 exactly 2 edges after the handshake; wr_addr = 16'h0040 held while wr_req is high; wr_count = 1; err_valid never asserted.
REQ-041 Five back-to-back commands with FIFO_DEPTH = 4 and no wr_done returned.
  - Response: cfg_ready drops after the FIFO fills; commands are issued in order; no command is lost.
REQ-042 Command with target = 7 and NUM_TARGETS = 4.
  - Response: wr_req stays 0; one err_valid pulse with err_code = 1 and err_target = 7; err_count = 1.
REQ-043 TIMEOUT_CYCLES = 8 and wr_done never returned.
  - Response: wr_req stays high for exactly 8 cycles, then err_code = 2; the next queued command proceeds.
REQ-044 wr_done asserted in the same cycle as timeout expiry.
  - Response: wr_count increments; err_valid stays 0.
REQ-045 reset_n asserted low while in WAIT with 2 commands queued.
  - Response: wr_req = 0 on the next edge; busy = 0; no queued command is issued after reset is released.
